// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  // One prefetch-queue entry: the fetch PC paired with its instruction word.
  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Ceiling log2 for sizing pointers and counters.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; DEPTH must be a power of two.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = clog2(DEPTH),
  localparam int unsigned CNT_W = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; empty/count gate every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited imem requests, prefetch queue, redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter logic [31:0] BOOT   = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_oe,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic              dec_valid,
  output logic [INST_W-1:0] dec_inst,
  output logic [31:0]       dec_pc,
  input  logic              dec_ready
);

  localparam int unsigned CNT_W = clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = $bits(fetch_entry_t);

  logic [31:0]      pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [CNT_W:0]   inflight;

  logic [31:0]      tag_head;
  logic [CNT_W-1:0] tag_count;
  logic             tag_full;
  logic             tag_empty;

  fetch_entry_t     q_in;
  fetch_entry_t     q_head;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;
  logic             q_push;
  logic             q_pop;
  logic             resp_live;
  logic             unused_ok;

  assign imem_addr = pc[ADDR_W-1:0];
  assign inflight  = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_oe   = !rst && !redirect && (inflight < (CNT_W+1)'(DEPTH));
  assign resp_live = !rst && imem_ready && (discard == '0) && !redirect;
  assign q_in      = '{pc: tag_head, inst: imem_rdata};
  assign q_pop     = dec_ready && !redirect && !q_empty;
  assign unused_ok = ^{tag_full, tag_empty, tag_count, q_full, redirect_pc[1:0]};

`ifdef FETCH_BYPASS_EN
  logic bypass;
  logic byp_take;
  assign bypass   = q_empty && resp_live;
  assign byp_take = bypass && dec_ready;
  assign q_push   = resp_live && !byp_take;
`else
  assign q_push   = resp_live;
`endif

  // PC tags of requests whose responses will be kept.
  fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (imem_oe),
    .push_data (pc),
    .pop       (resp_live),
    .flush     (redirect),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count),
    .head      (tag_head)
  );

  fetch_queue #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .flush     (redirect),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head      (q_head)
  );

  // A response arriving in the redirect cycle is dropped, so it is not counted into discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= BOOT;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(imem_oe) - CNT_W'(imem_ready);
      if (redirect) begin
        pc      <= {redirect_pc[31:2], 2'b00};
        discard <= outstanding - CNT_W'(imem_ready);
      end else begin
        if (imem_oe) pc <= pc + 32'd4;
        if (imem_ready && (discard != '0)) discard <= discard - CNT_W'(1);
      end
    end
  end

  always_comb begin
    dec_valid = !q_empty;
    dec_inst  = q_head.inst;
    dec_pc    = q_head.pc;
`ifdef FETCH_BYPASS_EN
    if (bypass) begin
      dec_valid = 1'b1;
      dec_inst  = imem_rdata;
      dec_pc    = tag_head;
    end
`endif
    if (!dec_valid) begin
      dec_inst = NOP_INST;
      dec_pc   = '0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order imem model with configurable latency and stalls.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [15:0] imem_addr;
  logic        imem_oe;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready = 1'b0;

  fetch_unit #(.ADDR_W(16), .DEPTH(4), .BOOT(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_oe     (imem_oe),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .dec_valid   (dec_valid),
    .dec_inst    (dec_inst),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          stamp;
  } req_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          lat = 1;
  bit          stall = 1'b0;
  bit          rand_mode = 1'b0;
  int          req_cnt = 0;
  int          first_hs = -1;
  int          last_hs = -1;
  req_t        reqq[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem_data [logic [31:0]];

`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Request capture: inputs settle well before the falling edge.
  always @(negedge clk) begin
    req_t r;
    if (!rst && imem_oe) begin
      r.addr  = {16'h0, imem_addr};
      r.stamp = cyc;
      reqq.push_back(r);
      req_cnt++;
    end
  end

  // In-order memory: respond once a request is at least lat cycles old.
  always @(posedge clk) begin
    req_t r;
    #1;
    if (rst) begin
      reqq.delete();
      imem_ready = 1'b0;
    end else if (!stall && reqq.size() > 0 && cyc >= reqq[0].stamp + lat) begin
      r = reqq.pop_front();
      if (!mem_data.exists(r.addr))
        mem_data[r.addr] = rand_mode ? $urandom : (32'hA5000000 | r.addr);
      imem_ready = 1'b1;
      imem_rdata = mem_data[r.addr];
    end else begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
    end
  end

  // Monitor: every decode handshake is checked against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    #1;
    if (dec_valid && dec_ready && !redirect) begin
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pc: got %h want none", dec_pc);
      end else begin
        e = exp_q.pop_front();
        chk("dec_pc", dec_pc, e);
        if (mem_data.exists(e)) chk("dec_inst", dec_inst, mem_data[e]);
        else begin
          vectors++;
          miscompares++;
          $display("FAIL dec_inst: got %h want data never returned for %h", dec_inst, e);
        end
      end
    end
  end

  task automatic do_reset;
    @(posedge clk);
    #2;
    rst = 1'b1;
    redirect = 1'b0;
    dec_ready = 1'b0;
    #1;
    chk("rst_oe", 32'(imem_oe), 32'h0);
    chk("rst_valid", 32'(dec_valid), 32'h0);
    chk("rst_inst", dec_inst, NOP_INST);
    chk("rst_pc", dec_pc, 32'h0);
    @(posedge clk);
    #2;
    req_cnt = 0;
    first_hs = -1;
    rst = 1'b0;
    t0 = cyc;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'h0);
    dec_ready = 1'b0;
  endtask

  initial begin
    // Streaming: one handshake per cycle after warm-up.
    do_reset();
    push_seq(32'h0, 16);
    dec_ready = 1'b1;
    wait_drain(40);
    chk("first_latency", 32'(first_hs - t0), 32'(FIRST_LAT));
    chk("throughput", 32'(last_hs - first_hs), 32'd15);

    // Back-pressure: credits stop fetch at DEPTH requests.
    do_reset();
    repeat (12) @(posedge clk);
    @(negedge clk);
    #2;
    chk("req_cnt", 32'(req_cnt), 32'd4);
    chk("oe_credit", 32'(imem_oe), 32'h0);
    push_seq(32'h0, 8);
    @(posedge clk);
    #2;
    dec_ready = 1'b1;
    wait_drain(40);

    // Redirect with two requests in flight.
    do_reset();
    lat = 3;
    @(posedge clk); #2;
    @(posedge clk); #2;
    redirect = 1'b1;
    redirect_pc = 32'h00000103;
    @(posedge clk); #2;
    redirect = 1'b0;
    @(negedge clk); #1;
    chk("redir_oe", 32'(imem_oe), 32'h1);
    chk("redir_addr", {16'h0, imem_addr}, 32'h00000100);
    push_seq(32'h100, 8);
    dec_ready = 1'b1;
    wait_drain(60);

    // Back-to-back redirects, each coinciding with a response.
    do_reset();
    lat = 2;
    @(posedge clk); #2;
    @(posedge clk); #2;
    redirect = 1'b1;
    redirect_pc = 32'h00000200;
    @(posedge clk); #2;
    redirect_pc = 32'h00000307;
    @(posedge clk); #2;
    redirect = 1'b0;
    @(negedge clk); #1;
    chk("redir2_addr", {16'h0, imem_addr}, 32'h00000304);
    push_seq(32'h304, 6);
    dec_ready = 1'b1;
    wait_drain(60);
    lat = 1;

    // Memory stall mid-stream with random data.
    do_reset();
    mem_data.delete();
    rand_mode = 1'b1;
    push_seq(32'h0, 16);
    dec_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    stall = 1'b0;
    wait_drain(60);
    rand_mode = 1'b0;

    // Asynchronous reset between edges mid-burst.
    do_reset();
    push_seq(32'h0, 16);
    dec_ready = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_oe", 32'(imem_oe), 32'h0);
    chk("arst_valid", 32'(dec_valid), 32'h0);
    chk("arst_inst", dec_inst, NOP_INST);
    chk("arst_pc", dec_pc, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #2;
    first_hs = -1;
    rst = 1'b0;
    t0 = cyc;
    push_seq(32'h0, 8);
    wait_drain(40);
    chk("restart_latency", 32'(first_hs - t0), 32'(FIRST_LAT));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
